// File: rtl/rpn_ctrl.sv
// rtl/rpn_ctrl.sv - RPN calculator controller: operand stack, token decode, external ALU sequencing
module rpn_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_is_op,
  input  logic [15:0]            in_data,
  output logic [3:0]             alu_op,
  output logic [15:0]            alu_left,
  output logic [15:0]            alu_right,
  input  logic [15:0]            alu_ans,
  input  logic [1:0]             alu_arg_cnt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_data,
  output logic                   err,
  output logic [2:0]             err_code,
  output logic [$clog2(DEPTH):0] depth
);

  localparam int IW  = $clog2(DEPTH);
  localparam int SPW = IW + 1;
  localparam logic [SPW-1:0] DEPTH_SP = SPW'(DEPTH);
  localparam logic [3:0]     OP_DIV   = 4'd3;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, OUT} state_t;

  state_t         state, state_nxt;
  logic [15:0]    stack [DEPTH];
  logic [SPW-1:0] sp;
  logic [1:0]     arg_cnt_q;
  logic [SPW-1:0] sp_m1, sp_m2;
  logic [15:0]    top, second;
  logic           push_ok, push_ovf, dec_err;
  logic [2:0]     dec_code;

  // Indices wrap harmlessly when sp is too small; DECODE guards every use.
  assign sp_m1  = sp - SPW'(1);
  assign sp_m2  = sp - SPW'(2);
  assign top    = stack[sp_m1[IW-1:0]];
  assign second = stack[sp_m2[IW-1:0]];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign depth     = sp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push_ok   = 1'b0;
    push_ovf  = 1'b0;
    dec_err   = 1'b0;
    dec_code  = 3'd0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_is_op)            state_nxt = DECODE;
          else if (sp < DEPTH_SP)  push_ok   = 1'b1;
          else                     push_ovf  = 1'b1;
        end
      end
      DECODE: begin
        if (alu_arg_cnt == 2'd0) begin
          dec_err  = 1'b1;
          dec_code = 3'd3;
        end else if (SPW'(alu_arg_cnt) > sp) begin
          dec_err  = 1'b1;
          dec_code = 3'd2;
        end else if (alu_op == OP_DIV && top == 16'd0) begin
          dec_err  = 1'b1;
          dec_code = 3'd4;
        end
        state_nxt = dec_err ? IDLE : EXEC;
      end
      EXEC:    state_nxt = (arg_cnt_q == 2'd1) ? OUT : IDLE;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stack[i] <= 16'd0;
      sp        <= '0;
      arg_cnt_q <= 2'd0;
      alu_op    <= 4'd0;
      alu_left  <= 16'd0;
      alu_right <= 16'd0;
      out_data  <= 16'd0;
      err       <= 1'b0;
      err_code  <= 3'd0;
    end else begin
      err <= 1'b0;
      if (push_ok) begin
        stack[sp[IW-1:0]] <= in_data;
        sp                <= sp + SPW'(1);
      end
      if (push_ovf) begin
        err      <= 1'b1;
        err_code <= 3'd1;
      end
      if (state == IDLE && in_valid && in_is_op) alu_op <= in_data[3:0];
      if (dec_err) begin
        err      <= 1'b1;
        err_code <= dec_code;
      end
      if (state == DECODE && !dec_err) begin
        arg_cnt_q <= alu_arg_cnt;
        if (alu_arg_cnt == 2'd1) begin
          alu_left  <= top;
          alu_right <= 16'd0;
        end else begin
          alu_left  <= second;
          alu_right <= top;
        end
      end
      // Unary ops consume the top entry into out_data; binary ops fold into the lower operand slot.
      if (state == EXEC) begin
        sp <= sp_m1;
        if (arg_cnt_q == 2'd1) out_data <= alu_ans;
        else                   stack[sp_m2[IW-1:0]] <= alu_ans;
      end
    end
  end

endmodule

// File: tb/tb_rpn_ctrl.sv
// tb/tb_rpn_ctrl.sv - self-checking bench for rpn_ctrl with a behavioural ALU and output scoreboard
module tb_rpn_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_is_op = 1'b0;
  logic [15:0] in_data = 16'd0;
  logic [3:0]  alu_op;
  logic [15:0] alu_left, alu_right, alu_ans;
  logic [1:0]  alu_arg_cnt;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        err;
  logic [2:0]  err_code;
  logic [3:0]  depth;

  int          total = 0;
  int          bad = 0;
  logic [15:0] sb [$];
  logic [15:0] mon_exp;

  always #5 clk = ~clk;

  rpn_ctrl #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_op(in_is_op), .in_data(in_data), .alu_op(alu_op),
    .alu_left(alu_left), .alu_right(alu_right), .alu_ans(alu_ans),
    .alu_arg_cnt(alu_arg_cnt), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .err(err), .err_code(err_code), .depth(depth)
  );

  always_comb begin
    alu_arg_cnt = 2'd0;
    alu_ans     = 16'd0;
    case (alu_op)
      4'd0: begin alu_arg_cnt = 2'd2; alu_ans = alu_left + alu_right; end
      4'd1: begin alu_arg_cnt = 2'd2; alu_ans = alu_left - alu_right; end
      4'd2: begin alu_arg_cnt = 2'd2; alu_ans = alu_left * alu_right; end
      4'd3: begin alu_arg_cnt = 2'd2; alu_ans = (alu_right == 16'd0) ? 16'd0 : alu_left / alu_right; end
      4'd4: begin alu_arg_cnt = 2'd1; alu_ans = alu_left; end
      default: ;
    endcase
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: got %0d, none expected", out_data);
      end else begin
        mon_exp = sb.pop_front();
        if (out_data !== mon_exp) begin
          bad++;
          $display("FAIL out_data: got %0d expected %0d", out_data, mon_exp);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL wait_ready: in_ready stuck at %0b, expected 1", in_ready);
    end
  endtask

  task automatic send_tok(input logic is_op, input logic [15:0] d);
    @(negedge clk);
    wait_ready();
    in_valid = 1'b1;
    in_is_op = is_op;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [15:0] v);
    send_tok(1'b0, v);
  endtask

  task automatic op(input logic [3:0] o);
    send_tok(1'b1, {12'h0, o});
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(sb.size() == 0 && in_ready) && n < 50);
    if (!(sb.size() == 0 && in_ready)) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d in_ready=%0b, expected 0 and 1", sb.size(), in_ready);
    end
  endtask

  task automatic do_pop(input logic [15:0] e);
    sb.push_back(e);
    op(4'd4);
    wait_drain();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({in_ready, out_valid, err, err_code, depth, alu_op, alu_left, alu_right, out_data} !==
        {1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0}) begin
      bad++;
      $display("FAIL reset_state: rdy=%0b ov=%0b err=%0b code=%0d depth=%0d op=%0d l=%0d r=%0d od=%0d",
               in_ready, out_valid, err, err_code, depth, alu_op, alu_left, alu_right, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset: got %0b expected 1", in_ready);
    end
  endtask

  task automatic test_add();
    push(16'd10);
    push(16'd20);
    total++;
    if (depth !== 4'd2) begin bad++; $display("FAIL add_depth2: got %0d expected 2", depth); end
    op(4'd0);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL add_decode_ready: got %0b expected 0", in_ready); end
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL add_exec_ready: got %0b expected 0", in_ready); end
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1 || depth !== 4'd1) begin
      bad++;
      $display("FAIL add_done: ready=%0b depth=%0d expected 1 and 1", in_ready, depth);
    end
    total++;
    if (alu_left !== 16'd10 || alu_right !== 16'd20 || alu_op !== 4'd0) begin
      bad++;
      $display("FAIL add_alu_hold: op=%0d l=%0d r=%0d expected 0 10 20", alu_op, alu_left, alu_right);
    end
    do_pop(16'd30);
    total++;
    if (depth !== 4'd0) begin bad++; $display("FAIL add_depth0: got %0d expected 0", depth); end
  endtask

  task automatic test_arith();
    logic [15:0] a, b, e;
    logic [3:0]  o;
    push(16'd20); push(16'd10); op(4'd1); do_pop(16'd10);
    push(16'd10); push(16'd20); op(4'd2); do_pop(16'd200);
    push(16'd20); push(16'd10); op(4'd3); do_pop(16'd2);
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      b = 16'($urandom_range(1, 65535));
      o = 4'($urandom_range(0, 3));
      case (o)
        4'd0:    e = a + b;
        4'd1:    e = a - b;
        4'd2:    e = a * b;
        default: e = a / b;
      endcase
      push(a); push(b); op(o); do_pop(e);
    end
  endtask

  task automatic test_errors();
    op(4'd0);
    @(posedge clk); #1;
    total++;
    if (err !== 1'b1 || err_code !== 3'd2 || depth !== 4'd0) begin
      bad++;
      $display("FAIL underflow: err=%0b code=%0d depth=%0d expected 1 2 0", err, err_code, depth);
    end
    @(posedge clk); #1;
    total++;
    if (err !== 1'b0 || err_code !== 3'd2) begin
      bad++;
      $display("FAIL err_pulse: err=%0b code=%0d expected 0 2", err, err_code);
    end
    push(16'd5); push(16'd6); op(4'hF);
    @(posedge clk); #1;
    total++;
    if (err !== 1'b1 || err_code !== 3'd3 || depth !== 4'd2) begin
      bad++;
      $display("FAIL unknown_op: err=%0b code=%0d depth=%0d expected 1 3 2", err, err_code, depth);
    end
    do_pop(16'd6); do_pop(16'd5);
    push(16'd20); push(16'd0); op(4'd3);
    @(posedge clk); #1;
    total++;
    if (err !== 1'b1 || err_code !== 3'd4 || depth !== 4'd2) begin
      bad++;
      $display("FAIL div_zero: err=%0b code=%0d depth=%0d expected 1 4 2", err, err_code, depth);
    end
    do_pop(16'd0); do_pop(16'd20);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) push(16'(i));
    push(16'd9);
    total++;
    if (err !== 1'b1 || err_code !== 3'd1 || depth !== 4'd8) begin
      bad++;
      $display("FAIL overflow: err=%0b code=%0d depth=%0d expected 1 1 8", err, err_code, depth);
    end
    @(posedge clk); #1;
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL ovf_pulse: err=%0b expected 0", err); end
    for (int i = 8; i >= 1; i--) do_pop(16'(i));
  endtask

  task automatic test_back_to_back();
    push(16'd1); push(16'd2); push(16'd3); push(16'd4);
    op(4'd0); op(4'd2); op(4'd1);
    do_pop(16'hFFF3);
    total++;
    if (depth !== 4'd0) begin bad++; $display("FAIL b2b_depth: got %0d expected 0", depth); end
  endtask

  task automatic test_backpressure_reset();
    out_ready = 1'b0;
    push(16'd77);
    sb.push_back(16'd77);
    op(4'd4);
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL pop_early: out_valid=%0b expected 0", out_valid); end
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'd77 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_%0d: ov=%0b od=%0d rdy=%0b expected 1 77 0", i, out_valid, out_data, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_drain();
    push(16'd3); push(16'd4); op(4'd0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, err, err_code, depth, alu_op, alu_left, alu_right, out_data} !==
        {1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0} || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL exec_reset: ov=%0b err=%0b code=%0d depth=%0d op=%0d l=%0d r=%0d od=%0d rdy=%0b",
               out_valid, err, err_code, depth, alu_op, alu_left, alu_right, out_data, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1 || depth !== 4'd0) begin
      bad++;
      $display("FAIL post_reset: rdy=%0b depth=%0d expected 1 0", in_ready, depth);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_arith();
    test_errors();
    test_overflow();
    test_back_to_back();
    test_backpressure_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rpn_ctrl.md
RPN_CTRL -- requirements
Module: rpn_ctrl

Interface
REQ-001 Parameter: DEPTH, 8, number of 16-bit operand stack entries (power of two, 2..16).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  in  1  token present.
REQ-005 Port: in_ready  out  1  controller accepts a token this cycle.
REQ-006 Port: in_is_op  in  1  1 = operator token, 0 = number token.
REQ-007 Port: in_data  in  16  number value, or opcode in bits [3:0] (bits [15:4] ignored for operators).
REQ-008 Port: alu_op  out  4  opcode to ALU (ADD=0, SUB=1, MUL=2, DIV=3, POP=4).
REQ-009 Port: alu_left / alu_right  out  16 each  ALU operands.
REQ-010 Port: alu_ans  in  16  combinational ALU result.
REQ-011 Port: alu_arg_cnt  in  2  operands required by alu_op (0 = unknown op).
REQ-012 Port: out_valid  out  1  result available; out_ready  in  1  consumer accepts.
REQ-013 Port: out_data  out  16  result of POP.
REQ-014 Port: err  out  1  one-cycle error pulse; err_code  out  3  last error cause.
REQ-015 Port: depth  out  log2(DEPTH)+1  current stack occupancy.

Function
REQ-016 The controller SHALL hold a DEPTH x 16 register stack with pointer sp (0..DEPTH); depth = sp.
REQ-017 The controller SHALL implement states IDLE, DECODE, EXEC, OUT; in_ready = 1 only in IDLE.
REQ-018 A token SHALL be accepted on a rising edge with in_valid && in_ready.
REQ-019 IDLE, number accepted, sp < DEPTH: stack[sp] <= in_data, sp <= sp+1, remain IDLE.
REQ-020 IDLE, number accepted, sp == DEPTH: stack unchanged, err pulse, err_code <= 1 (overflow), remain IDLE.
REQ-021 IDLE, operator accepted: alu_op <= in_data[3:0], go to DECODE.
REQ-022 DECODE (1 cycle), priority order: arg_cnt == 0 -> err_code 3 (unknown op); arg_cnt > sp -> err_code 2 (underflow); op == DIV and stack[sp-1] == 0 -> err_code 4 (divide by zero); each error pulses err, leaves the stack unchanged and returns to IDLE.
REQ-023 DECODE, no error: arg_cnt == 2 -> alu_left <= stack[sp-2], alu_right <= stack[sp-1]; arg_cnt == 1 -> alu_left <= stack[sp-1], alu_right <= 0; go to EXEC.
REQ-024 EXEC, arg_cnt == 2: stack[sp-2] <= alu_ans, sp <= sp-1, go to IDLE.
REQ-025 EXEC, arg_cnt == 1: out_data <= alu_ans, sp <= sp-1, go to OUT.
REQ-026 OUT: out_valid = 1 with out_data stable; on out_ready go to IDLE; otherwise hold indefinitely.
REQ-027 Latency: operator accepted at edge T; binary op completes at T+2 with in_ready high from T+2; POP raises out_valid from T+2.
REQ-028 Arithmetic width: alu_ans SHALL be stored unmodified (16-bit, ALU-defined truncation); the controller performs no arithmetic except sp increment/decrement.
REQ-029 err SHALL be high for exactly one cycle per error; err_code SHALL hold its value until the next error.
REQ-030 alu_op, alu_left and alu_right SHALL be registered and held outside DECODE/EXEC.
REQ-031 Tokens presented while in_ready = 0 SHALL be ignored and not lost; the source SHALL hold in_valid.

Reset
REQ-032 rst_n low SHALL immediately force: state IDLE, sp 0, all stack entries 0, alu_op 0, alu_left 0, alu_right 0, out_valid 0, out_data 0, err 0, err_code 0.
REQ-033 Reset in any state, including mid-EXEC or OUT, SHALL abort the operation with no stack write.
REQ-034 in_ready SHALL be 1 at the first edge after rst_n deasserts.

Verification
REQ-035 Push 10, push 20, op ADD, op POP -> depth 2, then 1, then 0; out_valid with out_data = 30.
REQ-036 Push 20, 10, SUB, POP -> 10; push 10, 20, MUL, POP -> 200; push 20, 10, DIV, POP -> 2.
REQ-037 Empty stack, op ADD -> err pulse, err_code 2, depth 0; op 0xF with depth 2 -> err_code 3, depth 2.
REQ-038 Push 20, 0, DIV -> err_code 4, depth 2, stack unchanged; then POP -> out_data 0.
REQ-039 Push 1..8 (DEPTH 8), push 9 -> err_code 1, depth 8; POP -> out_data 8.
REQ-040 POP with out_ready held 0 for 5 cycles -> out_valid and out_data stable, in_ready 0; assert rst_n low during a following EXEC -> all outputs 0, depth 0.
